// File: rtl/pwm_generator.sv
// PWM generator stepped by rising edges of a prescaler tick; period/duty are
// double-buffered and reach the active registers only at a period boundary or while stopped.
module pwm_generator #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm_o,
  output logic             cycle_o,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;

  logic             tick_q;
  logic             step;
  logic             boundary;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] act_period_nxt;
  logic [WIDTH-1:0] act_duty;
  logic [WIDTH-1:0] act_duty_nxt;
  logic [WIDTH-1:0] pend_period;
  logic [WIDTH-1:0] pend_period_nxt;
  logic [WIDTH-1:0] pend_duty;
  logic [WIDTH-1:0] pend_duty_nxt;
  logic             pend;
  logic             pend_nxt;
  logic             pwm_nxt;
  logic             cycle_nxt;

  assign step     = tick_i & ~tick_q;
  assign boundary = (act_period != '0) && (count == act_period - ONE);
  assign count_o  = count;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt       = count;
    act_period_nxt  = act_period;
    act_duty_nxt    = act_duty;
    pend_period_nxt = pend_period;
    pend_duty_nxt   = pend_duty;
    pend_nxt        = pend;
    pwm_nxt         = 1'b0;
    cycle_nxt       = 1'b0;

    if (load) begin
      pend_period_nxt = period;
      pend_duty_nxt   = duty;
      pend_nxt        = 1'b1;
    end

    case (state)
      IDLE: begin
        count_nxt = '0;
        // Stopped: pending values apply at once; a load this clk stays pending.
        if (pend) begin
          act_period_nxt = pend_period;
          act_duty_nxt   = pend_duty;
          if (!load) begin
            pend_nxt = 1'b0;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          count_nxt = '0;
        end else begin
          pwm_nxt = (act_period != '0) && (count < act_duty);
          if (step && (act_period != '0)) begin
            if (boundary) begin
              count_nxt = '0;
              cycle_nxt = 1'b1;
              // A load landing on the boundary bypasses the pending stage.
              if (load) begin
                act_period_nxt = period;
                act_duty_nxt   = duty;
                pend_nxt       = 1'b0;
              end else if (pend) begin
                act_period_nxt = pend_period;
                act_duty_nxt   = pend_duty;
                pend_nxt       = 1'b0;
              end
            end else begin
              count_nxt = count + ONE;
            end
          end
        end
      end
      default: begin
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      tick_q      <= 1'b0;
      count       <= '0;
      act_period  <= '0;
      act_duty    <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend        <= 1'b0;
      pwm_o       <= 1'b0;
      cycle_o     <= 1'b0;
    end else begin
      tick_q      <= tick_i;
      count       <= count_nxt;
      act_period  <= act_period_nxt;
      act_duty    <= act_duty_nxt;
      pend_period <= pend_period_nxt;
      pend_duty   <= pend_duty_nxt;
      pend        <= pend_nxt;
      pwm_o       <= pwm_nxt;
      cycle_o     <= cycle_nxt;
    end
  end

endmodule
